alu_cmd_ctrl: RTL and testbench

Command-side controller for the 16-bit-result ALU. It parses a byte stream of operand and function frames, stores the operands, and issues single-cycle ALU enables. It captures the registered ALU result and returns it as two bytes over a valid/ready transmit interface. It sits between the serial-receive byte path and the serial-transmit byte path of the system.

---
 rtl/alu_cmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Frame parser and result returner for the 16-bit ALU: CC,A,B,FUN or DD,FUN in, two result bytes out.
// Latency: last frame byte n -> ALU_EN n+1 -> capture n+2 -> first TX_VALID n+3; TX holds under backpressure.
module alu_cmd_ctrl #(
    parameter int             OPER_WIDTH = 8,
    parameter int             OUT_WIDTH  = 16,
    parameter logic [7:0]     CMD_OPER   = 8'hCC,
    parameter logic [7:0]     CMD_REUSE  = 8'hDD,
    parameter int             TIMEOUT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [OPER_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VALID,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    output logic [OPER_WIDTH-1:0] ALU_A,
    output logic [OPER_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic [OPER_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_RES, SEND_LO, SEND_HI
    } state_t;

    state_t                 state, state_nxt;
    logic [OUT_WIDTH-1:0]   result, result_nxt;
    logic [OPER_WIDTH-1:0]  a_nxt, b_nxt, tx_data_nxt;
    logic [3:0]             fun_nxt;
    logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_nxt;
    logic                   err_nxt;
    logic                   busy_now;

    assign busy_now = !(state inside {IDLE, GET_A, GET_B, GET_FUN});

    always_comb begin
        state_nxt   = state;
        a_nxt       = ALU_A;
        b_nxt       = ALU_B;
        fun_nxt     = ALU_FUN;
        result_nxt  = result;
        tx_data_nxt = TX_DATA;
        tmo_cnt_nxt = '0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (RX_VALID) begin
                    if (RX_DATA == CMD_OPER)
                        state_nxt = GET_A;
                    else if (RX_DATA == CMD_REUSE)
                        state_nxt = GET_FUN;
                    else
                        err_nxt = 1'b1;
                end
            end
            GET_A: begin
                if (RX_VALID) begin
                    a_nxt     = RX_DATA;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (RX_VALID) begin
                    b_nxt     = RX_DATA;
                    state_nxt = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_VALID) begin
                    fun_nxt   = RX_DATA[3:0];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT_RES;
            WAIT_RES: begin
                if (ALU_OUT_VALID) begin
                    result_nxt  = ALU_OUT;
                    tx_data_nxt = ALU_OUT[OPER_WIDTH-1:0];
                    state_nxt   = SEND_LO;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            SEND_LO: begin
                if (TX_READY) begin
                    tx_data_nxt = result[OUT_WIDTH-1 -: OPER_WIDTH];
                    state_nxt   = SEND_HI;
                end
            end
            SEND_HI: begin
                if (TX_READY)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Bytes arriving while the command is in flight are dropped, state untouched.
        if (RX_VALID && busy_now)
            err_nxt = 1'b1;
    end

    // Outputs are derived from the next state so they line up with the state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            result   <= '0;
            tmo_cnt  <= '0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_FUN  <= '0;
            ALU_EN   <= 1'b0;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_nxt;
            result   <= result_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            ALU_A    <= a_nxt;
            ALU_B    <= b_nxt;
            ALU_FUN  <= fun_nxt;
            ALU_EN   <= (state_nxt == ISSUE);
            TX_DATA  <= tx_data_nxt;
            TX_VALID <= (state_nxt inside {SEND_LO, SEND_HI});
            BUSY     <= !(state_nxt inside {IDLE, GET_A, GET_B, GET_FUN});
            ERR      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a one-cycle-latency ALU model and a TX/ERR/ALU_EN monitor.
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_DATA = '0;
    logic        RX_VALID = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VALID = 1'b0;
    logic [7:0]  ALU_A, ALU_B, TX_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, TX_VALID, BUSY, ERR;
    logic        TX_READY = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [15:0] model_res = '0;
    logic        model_on  = 1'b1;
    logic        en_d      = 1'b0;
    int          en_cnt    = 0;
    int          err_cnt   = 0;
    logic [7:0]  tx_q[$];

    alu_cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // ALU model and monitor run on the falling edge, away from the DUT's active edge.
    always @(negedge CLK) begin
        ALU_OUT_VALID = en_d && model_on;
        ALU_OUT       = model_res;
        en_d          = ALU_EN;
        if (ALU_EN) en_cnt++;
        if (ERR) err_cnt++;
        if (TX_VALID && TX_READY) tx_q.push_back(TX_DATA);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called at posedge+1; the byte is consumed on the next rising edge.
    task automatic rx(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick(1);
        RX_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (BUSY && k < 40) begin
            tick(1);
            k++;
        end
        chk("done_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic chk_tx(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        chk({tag, "_count"}, tx_q.size(), 32'd2);
        if (tx_q.size() == 2)
            chk({tag, "_bytes"}, {16'd0, tx_q[0], tx_q[1]}, {16'd0, lo, hi});
    endtask

    task automatic clr();
        tx_q.delete();
        en_cnt  = 0;
        err_cnt = 0;
    endtask

    initial begin
        #3;
        chk("reset_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY, ERR}, 32'd0);
        tick(1);
        RST = 1'b0;
        tick(1);

        // Basic frame with per-cycle latency checks
        clr();
        model_res = 16'h0008;
        rx(8'hCC); rx(8'h05); rx(8'h03); rx(8'h00);
        chk("t1_issue", {ALU_A, ALU_B, 4'd0, ALU_FUN, 6'd0, ALU_EN, BUSY}, {8'h05, 8'h03, 4'd0, 4'h0, 6'd0, 1'b1, 1'b1});
        tick(1);
        chk("t1_wait", {30'd0, ALU_EN, TX_VALID}, 32'd0);
        tick(1);
        chk("t1_lo", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h08});
        tick(1);
        chk("t1_hi", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h00});
        tick(1);
        chk("t1_end", {30'd0, TX_VALID, BUSY}, 32'd0);
        chk_tx("t1_tx", 8'h08, 8'h00);
        chk("t1_counts", {en_cnt[15:0], err_cnt[15:0]}, {16'd1, 16'd0});

        // Full-scale operands, then a reuse frame
        clr();
        model_res = 16'hFE01;
        rx(8'hCC); rx(8'hFF); rx(8'hFF); rx(8'h02);
        wait_done();
        chk_tx("t2_tx", 8'h01, 8'hFE);
        clr();
        model_res = 16'h01FE;
        rx(8'hDD); rx(8'h00);
        chk("t2_reuse_ops", {16'd0, ALU_A, ALU_B}, {16'd0, 8'hFF, 8'hFF});
        wait_done();
        chk_tx("t2_reuse_tx", 8'hFE, 8'h01);
        chk("t2_reuse_err", err_cnt, 32'd0);

        // Backpressure on the low byte
        clr();
        TX_READY  = 1'b0;
        model_res = 16'h1234;
        rx(8'hCC); rx(8'h01); rx(8'h02); rx(8'h03);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h34});
            tick(1);
        end
        TX_READY = 1'b1;
        tick(1);
        chk("t3_hi", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h12});
        wait_done();
        chk_tx("t3_tx", 8'h34, 8'h12);

        // Unknown header in IDLE
        clr();
        rx(8'h55);
        chk("t4_bad_hdr", {30'd0, ERR, BUSY}, {30'd0, 1'b1, 1'b0});
        tick(3);
        chk("t4_counts", {en_cnt[15:0], err_cnt[15:0]}, {16'd0, 16'd1});

        // Byte arriving during SEND_LO
        clr();
        TX_READY  = 1'b0;
        model_res = 16'hBEEF;
        rx(8'hCC); rx(8'h0A); rx(8'h0B); rx(8'h01);
        tick(2);
        rx(8'h77);
        chk("t5_busy_err", {22'd0, ERR, TX_VALID, TX_DATA}, {22'd0, 1'b1, 1'b1, 8'hEF});
        TX_READY = 1'b1;
        wait_done();
        chk_tx("t5_tx", 8'hEF, 8'hBE);
        chk("t5_err_cnt", err_cnt, 32'd1);

        // ALU never answers
        clr();
        model_on = 1'b0;
        rx(8'hCC); rx(8'h01); rx(8'h01); rx(8'h01);
        tick(4);
        chk("t6_pre_tmo", {31'd0, ERR}, 32'd0);
        tick(1);
        chk("t6_tmo", {29'd0, ERR, BUSY, TX_VALID}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("t6_no_tx", tx_q.size(), 32'd0);
        model_on  = 1'b1;
        model_res = 16'h0005;
        rx(8'hCC); rx(8'h02); rx(8'h03); rx(8'h00);
        wait_done();
        chk_tx("t6_after_tx", 8'h05, 8'h00);

        // Function code 1111 with upper nibble set, ALU returns zero
        clr();
        model_res = 16'h0000;
        rx(8'hCC); rx(8'h11); rx(8'h22); rx(8'hAF);
        chk("t7_fun", {28'd0, ALU_FUN}, 32'hF);
        wait_done();
        chk_tx("t7_tx", 8'h00, 8'h00);
        chk("t7_err", err_cnt, 32'd0);

        // Asynchronous reset mid-frame
        clr();
        rx(8'hCC); rx(8'h12);
        chk("t8_pre_rst_a", {24'd0, ALU_A}, 32'h12);
        #2 RST = 1'b1;
        #1;
        chk("t8_rst_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY, ERR}, 32'd0);
        tick(1);
        RST = 1'b0;
        rx(8'h34);
        chk("t8_hdr_34", {30'd0, ERR, BUSY}, {30'd0, 1'b1, 1'b0});
        rx(8'h00);
        chk("t8_hdr_00", {23'd0, ERR, ALU_B}, {23'd0, 1'b1, 8'h00});
        tick(1);
        chk("t8_quiet", {30'd0, ERR, ALU_EN}, 32'd0);

        // Reuse frame straight after reset uses zero operands
        clr();
        model_res = 16'h0000;
        rx(8'hDD); rx(8'h03);
        chk("t9_zero_ops", {12'd0, ALU_A, ALU_B, ALU_FUN}, {12'd0, 8'h00, 8'h00, 4'h3});
        wait_done();
        chk_tx("t9_tx", 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
